lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Shares the single LC3 memory port (addr, din, dout, rd, complete) between two requesters: port 0 is the CPU (Fetch/MemAccess path) and port 1 is a DMA/program-loader.
- Sits between the SimpleLC3 top-level memory pins and the external memory model.
- Sequences one transaction at a time: arbitrate, issue, wait for memory complete, return data with a one-cycle done pulse.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with CPU winning.
- TIMEOUT, 255, maximum BUSY cycles before abort; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  2  per-port request; bit0 = CPU, bit1 = DMA.
- req_addr0, req_addr1  in  AW  per-port address.
- req_wdata0, req_wdata1  in  DW  per-port write data.
- req_rd0, req_rd1  in  1  per-port direction; 1 = read, 0 = write.
- done  out  2  one-cycle completion pulse per port.
- err  out  2  with done, marks an aborted transaction.
- rdata  out  DW  read data, valid while any done bit is high.
- addr  out  AW  memory address.
- din  out  DW  write data to memory.
- rd  out  1  memory direction.
- mem_req  out  1  memory transaction active.
- dout  in  DW  read data from memory.
- complete  in  1  memory completion.
- gnt  out  2  one-hot owner of the current transaction.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - State goes to IDLE.
  - mem_req, done, err and gnt go to 0; addr, din and rdata go to 0; rd goes to 1.
  - The last-grant pointer is set to DMA, so the CPU wins the first round-robin tie.
  - Reset during BUSY abandons the transaction; no done pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req != 0, select the winner.
  - Round-robin: the port other than last-grant wins when both request.
  - Fixed priority: the CPU always wins when it requests.
  - Register addr, din, rd and gnt from the winner; assert mem_req; go to BUSY.
  - Latency: req sampled at edge N gives mem_req and addr valid after edge N.
- BUSY:
  - addr, din, rd and mem_req are held constant.
  - On complete == 1: capture dout into rdata (for reads only; writes leave rdata unchanged), drop mem_req, pulse done[gnt] for one cycle, update last-grant, go to DONE.
  - Complete at edge M gives done high for the cycle after edge M.
- DONE:
  - One cycle with gnt still valid and done high; then go to IDLE and clear gnt.
  - Earliest next mem_req is two cycles after complete. This gives one guaranteed idle cycle between transactions.
- Requester protocol:
  - Hold req and its fields stable until the done pulse; deassert in the done cycle or re-request.
  - A req dropped mid-BUSY is tolerated: the transaction still completes and done still pulses.
- Complete asserted in IDLE or DONE is ignored.
- Requests arriving during BUSY or DONE wait; there is no queueing beyond the req level.
- err is 0 unless the optional feature aborts a transaction.

Optional Feature:
- Macro: LC3_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit (clog2(TIMEOUT+1)) counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT with no complete: drop mem_req, set rdata = 0, pulse done[gnt] with err[gnt] = 1, go to DONE.
  - Complete arriving on the same cycle as the timeout wins: normal completion, err = 0.
- When undefined: no counter; BUSY waits indefinitely; err is tied to 0.

Decomposition:
- Shared package lc3_arb_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - port index constants PORT_CPU = 0 and PORT_DMA = 1;
  - ARB_RR = 0 and ARB_FIXED = 1.
- One sub-module, lc3_rr_pick: a combinational 2-way picker taking req, last-grant and mode, producing a one-hot grant. Everything else stays in the top.

Test Plan:
- Single CPU read: req = 01, addr0 = 16'h3000, memory completes 3 cycles later with dout = 16'h1234.
  - mem_req high for exactly 4 cycles; addr = 3000; rd = 1.
  - done = 01 with rdata = 1234 one cycle after complete.
- Contention, round-robin:
  - req = 11 held through three transactions after reset.
  - Grants go CPU, DMA, CPU; one idle cycle between each mem_req.
- Fixed priority: ARB_MODE = 1, req = 11 held for three transactions. Grants go CPU, CPU, CPU; DMA is never granted.
- DMA write:
  - req = 10, addr1 = 16'h0040, wdata1 = 16'hBEEF, rd1 = 0.
  - din = BEEF and rd = 0 while BUSY; done = 10; rdata keeps its prior value.
- Reset mid-transaction: reset = 0 in the second BUSY cycle.
  - Next cycle: mem_req = 0, gnt = 0, no done pulse.
  - After reset release with req = 11, the CPU is granted first.
- Timeout (macro defined, TIMEOUT = 8): complete never asserted.
  - Exactly 8 BUSY cycles, then done = 01, err = 01, rdata = 0.
  - A repeat run with complete on the 8th cycle gives err = 0.

Source files
------------

// File: rtl/lc3_arb_pkg.sv
// Shared types and constants for the LC3 memory-port arbiter.
package lc3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int unsigned PORT_CPU  = 0;
  localparam int unsigned PORT_DMA  = 1;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/lc3_rr_pick.sv
// Combinational 2-way picker: one-hot grant from req, last grant and arbitration mode.
module lc3_rr_pick
  import lc3_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       mode,
  output logic [1:0] grant_c
);

  // Only a two-way tie needs a policy; a single requester always wins.
  always_comb begin
    grant_c = req;
    if (req == 2'b11) begin
      if (mode == 1'(ARB_FIXED) || last_grant == 1'(PORT_DMA)) begin
        grant_c = 2'b01;
      end else begin
        grant_c = 2'b10;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the LC3 memory port between the CPU (port 0) and a DMA/loader (port 1).
// Optional BUSY watchdog with error completion enabled by LC3_ARB_TIMEOUT_EN.
module lc3_mem_arbiter
  import lc3_arb_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  input  logic          req_rd0,
  input  logic          req_rd1,
  output logic [1:0]    done,
  output logic [1:0]    err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] din,
  output logic          rd,
  output logic          mem_req,
  input  logic [DW-1:0] dout,
  input  logic          complete,
  output logic [1:0]    gnt
);

  arb_state_e    state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [1:0]    pick_c;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] din_nxt, rdata_nxt;
  logic          rd_nxt, mem_req_nxt;
  logic [1:0]    gnt_nxt, done_nxt;
  logic          timeout_c;

`ifdef LC3_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    err_nxt;

  // cnt counts elapsed BUSY cycles; the last allowed one is TIMEOUT-1.
  assign timeout_c = (cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
  assign err       = 2'b00;
`endif

  lc3_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .mode       (1'(ARB_MODE)),
    .grant_c    (pick_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nxt = BUSY;
      BUSY:    if (complete || timeout_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; memory-side fields hold through BUSY.
  always_comb begin
    addr_nxt       = addr;
    din_nxt        = din;
    rd_nxt         = rd;
    mem_req_nxt    = mem_req;
    gnt_nxt        = gnt;
    done_nxt       = 2'b00;
    rdata_nxt      = rdata;
    last_grant_nxt = last_grant;
`ifdef LC3_ARB_TIMEOUT_EN
    cnt_nxt        = cnt;
    err_nxt        = 2'b00;
`endif
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_nxt     = pick_c;
          mem_req_nxt = 1'b1;
          if (pick_c[PORT_DMA]) begin
            addr_nxt = req_addr1;
            din_nxt  = req_wdata1;
            rd_nxt   = req_rd1;
          end else begin
            addr_nxt = req_addr0;
            din_nxt  = req_wdata0;
            rd_nxt   = req_rd0;
          end
`ifdef LC3_ARB_TIMEOUT_EN
          cnt_nxt = '0;
`endif
        end
      end
      BUSY: begin
        if (complete) begin
          mem_req_nxt    = 1'b0;
          done_nxt       = gnt;
          last_grant_nxt = gnt[PORT_DMA];
          if (rd) rdata_nxt = dout;
        end
`ifdef LC3_ARB_TIMEOUT_EN
        else if (timeout_c) begin
          mem_req_nxt    = 1'b0;
          done_nxt       = gnt;
          err_nxt        = gnt;
          rdata_nxt      = '0;
          last_grant_nxt = gnt[PORT_DMA];
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      DONE: gnt_nxt = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      addr       <= '0;
      din        <= '0;
      rd         <= 1'b1;
      mem_req    <= 1'b0;
      gnt        <= 2'b00;
      done       <= 2'b00;
      rdata      <= '0;
      last_grant <= 1'(PORT_DMA);
`ifdef LC3_ARB_TIMEOUT_EN
      cnt        <= '0;
      err        <= 2'b00;
`endif
    end else begin
      addr       <= addr_nxt;
      din        <= din_nxt;
      rd         <= rd_nxt;
      mem_req    <= mem_req_nxt;
      gnt        <= gnt_nxt;
      done       <= done_nxt;
      rdata      <= rdata_nxt;
      last_grant <= last_grant_nxt;
`ifdef LC3_ARB_TIMEOUT_EN
      cnt        <= cnt_nxt;
      err        <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: round-robin and fixed-priority instances,
// each with its own latency-programmable memory model.
module tb_lc3_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0][1:0]  req;
  logic [1:0][15:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]       req_rd0, req_rd1;
  logic [1:0][1:0]  done, err, gnt;
  logic [1:0][15:0] rdata, addr, din;
  logic [1:0][15:0] dout = '0;
  logic [1:0]       rd, mem_req;
  logic [1:0]       complete = '0;

  lc3_mem_arbiter #(.AW(16), .DW(16), .ARB_MODE(0), .TIMEOUT(8)) u_rr (
    .clock(clock), .reset(reset), .req(req[0]),
    .req_addr0(req_addr0[0]), .req_addr1(req_addr1[0]),
    .req_wdata0(req_wdata0[0]), .req_wdata1(req_wdata1[0]),
    .req_rd0(req_rd0[0]), .req_rd1(req_rd1[0]),
    .done(done[0]), .err(err[0]), .rdata(rdata[0]), .addr(addr[0]), .din(din[0]),
    .rd(rd[0]), .mem_req(mem_req[0]), .dout(dout[0]), .complete(complete[0]), .gnt(gnt[0])
  );

  lc3_mem_arbiter #(.AW(16), .DW(16), .ARB_MODE(1), .TIMEOUT(8)) u_fx (
    .clock(clock), .reset(reset), .req(req[1]),
    .req_addr0(req_addr0[1]), .req_addr1(req_addr1[1]),
    .req_wdata0(req_wdata0[1]), .req_wdata1(req_wdata1[1]),
    .req_rd0(req_rd0[1]), .req_rd1(req_rd1[1]),
    .done(done[1]), .err(err[1]), .rdata(rdata[1]), .addr(addr[1]), .din(din[1]),
    .rd(rd[1]), .mem_req(mem_req[1]), .dout(dout[1]), .complete(complete[1]), .gnt(gnt[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat [2]  = '{4, 4};
  int mcnt [2] = '{0, 0};
  int last_done_cyc [2] = '{0, 0};

  logic [15:0] mem     [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  always @(posedge clock) cyc <= cyc + 1;

  // Contents of never-written locations.
  function automatic logic [15:0] img(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : img(a);
  endfunction

  // Memory: completes lat cycles after mem_req rises; writes land on completion.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_req[i]) begin
        mcnt[i]     = mcnt[i] + 1;
        complete[i] = (mcnt[i] == lat[i]);
        if (mcnt[i] == lat[i]) begin
          if (rd[i]) dout[i] = mem.exists(addr[i]) ? mem[addr[i]] : img(addr[i]);
          else begin
            dout[i] = 16'hDEAD;
            mem[addr[i]] = din[i];
          end
        end
      end else begin
        mcnt[i]     = 0;
        complete[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req[0] = 2'b00;
    req[1] = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // One transaction on instance i, checked from request to done pulse.
  task automatic do_txn(input int i, input logic [1:0] r,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic r0, input logic r1, input int l,
                        input logic [1:0] exp_done, input logic [1:0] exp_err,
                        input logic [15:0] exp_rdata, input bit hold, input bit chk_gap,
                        input string name);
    int nreq = 0;
    bit seen = 0;
    bit got  = 0;
    logic [15:0] ea, ew;
    logic er;
    ea = exp_done[1] ? a1 : a0;
    ew = exp_done[1] ? w1 : w0;
    er = exp_done[1] ? r1 : r0;
    lat[i] = l;
    req_addr0[i] = a0;  req_addr1[i] = a1;
    req_wdata0[i] = w0; req_wdata1[i] = w1;
    req_rd0[i] = r0;    req_rd1[i] = r1;
    req[i] = r;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clock);
      #1;
      if (mem_req[i]) begin
        nreq++;
        if (!seen) begin
          seen = 1;
          chk({name, " gnt"}, 32'(gnt[i]), 32'(exp_done));
          chk({name, " addr"}, 32'(addr[i]), 32'(ea));
          chk({name, " rd"}, 32'(rd[i]), 32'(er));
          if (!er) chk({name, " din"}, 32'(din[i]), 32'(ew));
          if (chk_gap) chk({name, " gap"}, 32'(cyc - last_done_cyc[i]), 32'd2);
        end
      end
      if (done[i] != 2'b00) begin
        got = 1;
        chk({name, " done"}, 32'(done[i]), 32'(exp_done));
        chk({name, " err"}, 32'(err[i]), 32'(exp_err));
        chk({name, " rdata"}, 32'(rdata[i]), 32'(exp_rdata));
        chk({name, " gnt_in_done"}, 32'(gnt[i]), 32'(exp_done));
        chk({name, " busy_cycles"}, 32'(nreq), 32'((exp_err != 2'b00) ? 8 : l));
        last_done_cyc[i] = cyc;
        if (!er && exp_err == 2'b00) ref_mem[ea] = ew;
        if (!hold) req[i] = 2'b00;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s no_done actual=none required=%0h", name, exp_done);
    end
  endtask

  typedef struct {
    logic [1:0]  r;
    logic [15:0] a0, a1, w0, w1;
    logic        r0, r1;
    int          l;
    logic [1:0]  exp_done;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [1:0]  r, ed;
    logic [15:0] a0, a1, w0, w1, prev, wa;
    logic        r0, r1, wrd, ml, win;
    int          l;
    bit          ok;

    for (int i = 0; i < 2; i++) begin
      req[i] = 2'b00; req_addr0[i] = '0; req_addr1[i] = '0;
      req_wdata0[i] = '0; req_wdata1[i] = '0; req_rd0[i] = 1'b1; req_rd1[i] = 1'b1;
    end

    vecs[0] = '{2'b01, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 4, 2'b01, 16'h1234};
    vecs[1] = '{2'b10, 16'h0000, 16'h0040, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 3, 2'b10, 16'h1234};
    vecs[2] = '{2'b10, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1'b1, 1, 2'b10, 16'hBEEF};
    vecs[3] = '{2'b11, 16'h0040, 16'h0041, 16'h0000, 16'h0000, 1'b1, 1'b1, 2, 2'b01, 16'hBEEF};
    vecs[4] = '{2'b11, 16'h0100, 16'h0041, 16'h5555, 16'h0000, 1'b0, 1'b1, 2, 2'b10, 16'hA5E4};
    vecs[5] = '{2'b11, 16'h0100, 16'h0100, 16'h0000, 16'h7777, 1'b1, 1'b0, 5, 2'b01, 16'hA4A5};
    vecs[6] = '{2'b11, 16'h0100, 16'h0100, 16'h0000, 16'h7777, 1'b1, 1'b0, 1, 2'b10, 16'hA4A5};
    vecs[7] = '{2'b01, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 2, 2'b01, 16'h7777};

    do_reset();
    for (int i = 0; i < 2; i++) begin
      chk("reset mem_req", 32'(mem_req[i]), 32'd0);
      chk("reset done", 32'(done[i]), 32'd0);
      chk("reset err", 32'(err[i]), 32'd0);
      chk("reset gnt", 32'(gnt[i]), 32'd0);
      chk("reset addr", 32'(addr[i]), 32'd0);
      chk("reset din", 32'(din[i]), 32'd0);
      chk("reset rdata", 32'(rdata[i]), 32'd0);
      chk("reset rd", 32'(rd[i]), 32'd1);
    end

    for (int k = 0; k < 8; k++)
      do_txn(0, vecs[k].r, vecs[k].a0, vecs[k].a1, vecs[k].w0, vecs[k].w1,
             vecs[k].r0, vecs[k].r1, vecs[k].l, vecs[k].exp_done, 2'b00,
             vecs[k].exp_rdata, 1'b0, k > 0, $sformatf("vec%0d", k));

    // Reset in the second BUSY cycle abandons the transaction.
    lat[0] = 1000;
    req_addr0[0] = 16'h0500;
    req_rd0[0] = 1'b1;
    req[0] = 2'b01;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clock);
      #1;
      ok = mem_req[0];
    end
    chk("midrst busy_reached", 32'(ok), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst mem_req", 32'(mem_req[0]), 32'd0);
    chk("midrst gnt", 32'(gnt[0]), 32'd0);
    chk("midrst done", 32'(done[0]), 32'd0);
    reset = 1'b1;

    // Round-robin contention with req held: CPU, DMA, CPU.
    do_txn(0, 2'b11, 16'h0200, 16'h0300, 16'h0, 16'h0, 1'b1, 1'b1, 2, 2'b01, 2'b00, 16'hA7A5, 1'b1, 1'b0, "rr1");
    do_txn(0, 2'b11, 16'h0200, 16'h0300, 16'h0, 16'h0, 1'b1, 1'b1, 2, 2'b10, 2'b00, 16'hA6A5, 1'b1, 1'b1, "rr2");
    do_txn(0, 2'b11, 16'h0200, 16'h0300, 16'h0, 16'h0, 1'b1, 1'b1, 2, 2'b01, 2'b00, 16'hA7A5, 1'b0, 1'b1, "rr3");

    // Fixed priority: CPU keeps winning.
    do_txn(1, 2'b11, 16'h0600, 16'h0700, 16'h0, 16'h0, 1'b1, 1'b1, 2, 2'b01, 2'b00, 16'hA3A5, 1'b1, 1'b0, "fx1");
    do_txn(1, 2'b11, 16'h0600, 16'h0700, 16'h0, 16'h0, 1'b1, 1'b1, 3, 2'b01, 2'b00, 16'hA3A5, 1'b1, 1'b1, "fx2");
    do_txn(1, 2'b11, 16'h0600, 16'h0700, 16'h0, 16'h0, 1'b1, 1'b1, 1, 2'b01, 2'b00, 16'hA3A5, 1'b0, 1'b1, "fx3");

    // Randomized traffic against a transaction-level round-robin model.
    do_reset();
    ml = 1'b1;
    prev = 16'h0000;
    for (int k = 0; k < 40; k++) begin
      r  = 2'($urandom_range(1, 3));
      a0 = 16'h0800 + 16'($urandom_range(0, 3));
      a1 = 16'h0800 + 16'($urandom_range(0, 3));
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      l  = $urandom_range(1, 6);
      win = (r == 2'b11) ? ~ml : (r == 2'b10);
      wa  = win ? a1 : a0;
      wrd = win ? r1 : r0;
      if (wrd) prev = ref_read(wa);
      ed = win ? 2'b10 : 2'b01;
      do_txn(0, r, a0, a1, w0, w1, r0, r1, l, ed, 2'b00, prev,
             1'($urandom_range(0, 1)), k > 0, $sformatf("rand%0d", k));
      ml = win;
    end

`ifdef LC3_ARB_TIMEOUT_EN
    do_txn(0, 2'b01, 16'h0900, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1000, 2'b01, 2'b01, 16'h0000, 1'b0, 1'b0, "tmo_abort");
    do_txn(0, 2'b01, 16'h0900, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 8, 2'b01, 2'b00, 16'hACA5, 1'b0, 1'b1, "tmo_race");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
